// File: rtl/read_from_cache.sv
// Read-side cache way access: one-hot way select, fixed-latency capture, valid/ready response.
// Optional macro READ_FROM_CACHE_ONEHOT_CHECK_EN rejects non-one-hot requests with rsp_err.
module read_from_cache #(
    parameter int NUM_WAYS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NUM_WAYS-1:0]          req_way,
    output logic [NUM_WAYS-1:0]          way_ren,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0] way_data_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err
);

    localparam int CNT_W = 2;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("read_from_cache: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                r_state;
    logic [NUM_WAYS-1:0]   r_sel;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_WAYS-1:0]   r_way_ren;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [DATA_WIDTH-1:0] w_mux_data;
    logic                  w_capture;
    logic                  w_accept;
    logic                  w_legal;

`ifdef READ_FROM_CACHE_ONEHOT_CHECK_EN
    localparam logic [NUM_WAYS-1:0] WAY_ONE = NUM_WAYS'(1);
    logic r_rsp_err;

    assign w_legal = (req_way != '0) && ((req_way & (req_way - WAY_ONE)) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rsp_err <= 1'b0;
        else if (w_accept)
            r_rsp_err <= ~w_legal;
        else if (w_capture)
            r_rsp_err <= 1'b0;
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_legal = 1'b1;
    assign rsp_err = 1'b0;
`endif

    // NOTE: gating with rst keeps req_ready low for the whole reset window, not just until the next edge.
    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_capture = ((r_state == ISSUE) && (READ_LATENCY == 1)) ||
                       ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

    // AND-OR mux: multi-hot selects OR their words together, zero select yields zero.
    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            w_mux_data |= {DATA_WIDTH{r_sel[i]}} & way_data_out[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_way_ren   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_way_ren <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sel <= req_way;
                        if (w_legal) begin
                            r_way_ren <= req_way;
                            r_state   <= ISSUE;
                        end else begin
                            r_rsp_data  <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= CNT_W'(READ_LATENCY - 1);
                    if (w_capture) begin
                        r_rsp_data  <= w_mux_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_capture) begin
                        r_rsp_data  <= w_mux_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign way_ren   = r_way_ren;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_read_from_cache.sv
// Directed bench for read_from_cache: latency-1 and latency-3 instances share way data and reset.
module tb_read_from_cache;

    localparam int NW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NW-1:0]   req_way = '0;
    logic [NW*DW-1:0] way_data = '0;

    logic            req_valid1 = 1'b0, rsp_ready1 = 1'b0;
    logic            req_ready1, rsp_valid1, rsp_err1;
    logic [NW-1:0]   way_ren1;
    logic [DW-1:0]   rsp_data1;

    logic            req_valid3 = 1'b0, rsp_ready3 = 1'b0;
    logic            req_ready3, rsp_valid3, rsp_err3;
    logic [NW-1:0]   way_ren3;
    logic [DW-1:0]   rsp_data3;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    read_from_cache #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_way(req_way), .way_ren(way_ren1), .way_data_out(way_data),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1)
    );

    read_from_cache #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_way(req_way), .way_ren(way_ren3), .way_data_out(way_data),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_way(input int idx, input logic [DW-1:0] val);
        way_data[idx*DW +: DW] = val;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_compared++; if (way_ren1 !== 4'b0000) begin n_mismatched++; $display("FAIL reset_way_ren: got %b exp 0000", way_ren1); end
        n_compared++; if (rsp_valid1 !== 1'b0) begin n_mismatched++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid1); end
        n_compared++; if (rsp_data1 !== 32'h0) begin n_mismatched++; $display("FAIL reset_rsp_data: got %h exp 0", rsp_data1); end
        n_compared++; if (rsp_err1 !== 1'b0) begin n_mismatched++; $display("FAIL reset_rsp_err: got %b exp 0", rsp_err1); end
        n_compared++; if (req_ready1 !== 1'b0) begin n_mismatched++; $display("FAIL reset_req_ready_in_rst: got %b exp 0", req_ready1); end
        rst = 1'b0;
        tick();
        n_compared++; if (req_ready1 !== 1'b1) begin n_mismatched++; $display("FAIL reset_req_ready_after: got %b exp 1", req_ready1); end
    endtask

    task automatic test_single_read();
        set_way(0, 32'h0000_0AAA); set_way(1, 32'h1234_5678);
        set_way(2, 32'hDEAD_BEEF); set_way(3, 32'hCAFE_F00D);
        req_way = 4'b0100; rsp_ready1 = 1'b1; req_valid1 = 1'b1;
        tick();  // cycle T+1
        req_valid1 = 1'b0;
        n_compared++; if (way_ren1 !== 4'b0100) begin n_mismatched++; $display("FAIL single_way_ren: got %b exp 0100", way_ren1); end
        n_compared++; if (rsp_valid1 !== 1'b0) begin n_mismatched++; $display("FAIL single_early_valid: got %b exp 0", rsp_valid1); end
        n_compared++; if (req_ready1 !== 1'b0) begin n_mismatched++; $display("FAIL single_req_ready_busy: got %b exp 0", req_ready1); end
        tick();  // cycle T+2
        n_compared++; if (way_ren1 !== 4'b0000) begin n_mismatched++; $display("FAIL single_ren_pulse: got %b exp 0000", way_ren1); end
        n_compared++; if (rsp_valid1 !== 1'b1) begin n_mismatched++; $display("FAIL single_rsp_valid: got %b exp 1", rsp_valid1); end
        n_compared++; if (rsp_data1 !== 32'hDEAD_BEEF) begin n_mismatched++; $display("FAIL single_rsp_data: got %h exp deadbeef", rsp_data1); end
        n_compared++; if (rsp_err1 !== 1'b0) begin n_mismatched++; $display("FAIL single_rsp_err: got %b exp 0", rsp_err1); end
        tick();  // cycle R+1
        n_compared++; if (rsp_valid1 !== 1'b0) begin n_mismatched++; $display("FAIL single_valid_drop: got %b exp 0", rsp_valid1); end
        n_compared++; if (req_ready1 !== 1'b1) begin n_mismatched++; $display("FAIL single_ready_back: got %b exp 1", req_ready1); end
    endtask

    task automatic test_latency3();
        set_way(0, 32'h0000_1111);
        req_way = 4'b0001; rsp_ready3 = 1'b1; req_valid3 = 1'b1;
        tick();  // T+1
        req_valid3 = 1'b0;
        n_compared++; if (way_ren3 !== 4'b0001) begin n_mismatched++; $display("FAIL lat3_way_ren: got %b exp 0001", way_ren3); end
        tick();  // T+2
        n_compared++; if (way_ren3 !== 4'b0000) begin n_mismatched++; $display("FAIL lat3_ren_pulse: got %b exp 0000", way_ren3); end
        n_compared++; if (rsp_valid3 !== 1'b0) begin n_mismatched++; $display("FAIL lat3_valid_t2: got %b exp 0", rsp_valid3); end
        tick();  // T+3
        n_compared++; if (rsp_valid3 !== 1'b0) begin n_mismatched++; $display("FAIL lat3_valid_t3: got %b exp 0", rsp_valid3); end
        set_way(0, 32'h0000_2222);
        tick();  // T+4
        set_way(0, 32'h0000_3333);
        n_compared++; if (rsp_valid3 !== 1'b1) begin n_mismatched++; $display("FAIL lat3_valid_t4: got %b exp 1", rsp_valid3); end
        n_compared++; if (rsp_data3 !== 32'h0000_2222) begin n_mismatched++; $display("FAIL lat3_rsp_data: got %h exp 00002222", rsp_data3); end
        tick();
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        set_way(3, 32'hA5A5_0001);
        req_way = 4'b1000; rsp_ready1 = 1'b0; req_valid1 = 1'b1;
        tick();  // T+1
        tick();  // T+2
        n_compared++; if (rsp_data1 !== 32'hA5A5_0001) begin n_mismatched++; $display("FAIL bp_rsp_data: got %h exp a5a50001", rsp_data1); end
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_way(3, 32'h5A5A_0000 + i);
            tick();
            if (rsp_valid1 !== 1'b1 || req_ready1 !== 1'b0 || rsp_data1 !== 32'hA5A5_0001)
                stable_ok = 1'b0;
        end
        n_compared++; if (stable_ok !== 1'b1) begin n_mismatched++; $display("FAIL bp_stall_hold: got valid=%b ready=%b data=%h exp 1 0 a5a50001", rsp_valid1, req_ready1, rsp_data1); end
        set_way(1, 32'h0BAD_F00D);
        req_way = 4'b0010;
        rsp_ready1 = 1'b1;
        tick();  // R+1
        n_compared++; if (rsp_valid1 !== 1'b0) begin n_mismatched++; $display("FAIL bp_valid_drop: got %b exp 0", rsp_valid1); end
        n_compared++; if (req_ready1 !== 1'b1) begin n_mismatched++; $display("FAIL bp_ready_back: got %b exp 1", req_ready1); end
        tick();  // next request issued
        req_valid1 = 1'b0;
        n_compared++; if (way_ren1 !== 4'b0010) begin n_mismatched++; $display("FAIL bp_next_ren: got %b exp 0010", way_ren1); end
        tick();
        n_compared++; if (rsp_data1 !== 32'h0BAD_F00D) begin n_mismatched++; $display("FAIL bp_next_data: got %h exp 0badf00d", rsp_data1); end
        tick();
    endtask

    task automatic test_multihot();
        set_way(1, 32'h0000_00F0); set_way(2, 32'h0000_0F00);
        req_way = 4'b0110; rsp_ready1 = 1'b1; req_valid1 = 1'b1;
        tick();  // T+1
        req_valid1 = 1'b0;
`ifdef READ_FROM_CACHE_ONEHOT_CHECK_EN
        n_compared++; if (way_ren1 !== 4'b0000) begin n_mismatched++; $display("FAIL err_no_ren: got %b exp 0000", way_ren1); end
        n_compared++; if (rsp_valid1 !== 1'b1) begin n_mismatched++; $display("FAIL err_valid: got %b exp 1", rsp_valid1); end
        n_compared++; if (rsp_err1 !== 1'b1) begin n_mismatched++; $display("FAIL err_flag: got %b exp 1", rsp_err1); end
        n_compared++; if (rsp_data1 !== 32'h0) begin n_mismatched++; $display("FAIL err_data: got %h exp 0", rsp_data1); end
        tick();
        req_way = 4'b0000; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        n_compared++; if (rsp_err1 !== 1'b1 || rsp_valid1 !== 1'b1) begin n_mismatched++; $display("FAIL err_zero_way: got err=%b valid=%b exp 1 1", rsp_err1, rsp_valid1); end
        tick();
`else
        n_compared++; if (way_ren1 !== 4'b0110) begin n_mismatched++; $display("FAIL multi_ren: got %b exp 0110", way_ren1); end
        tick();  // T+2
        n_compared++; if (rsp_data1 !== 32'h0000_0FF0) begin n_mismatched++; $display("FAIL multi_data: got %h exp 00000ff0", rsp_data1); end
        n_compared++; if (rsp_err1 !== 1'b0) begin n_mismatched++; $display("FAIL multi_err: got %b exp 0", rsp_err1); end
        tick();
        req_way = 4'b0000; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        n_compared++; if (way_ren1 !== 4'b0000) begin n_mismatched++; $display("FAIL zero_ren: got %b exp 0000", way_ren1); end
        tick();
        n_compared++; if (rsp_valid1 !== 1'b1 || rsp_data1 !== 32'h0) begin n_mismatched++; $display("FAIL zero_data: got valid=%b data=%h exp 1 0", rsp_valid1, rsp_data1); end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        logic quiet_ok;
        set_way(2, 32'h7777_0000);
        req_way = 4'b0100; rsp_ready3 = 1'b1; req_valid3 = 1'b1;
        tick();  // T+1
        req_valid3 = 1'b0;
        tick();  // T+2, in WAIT
        rst = 1'b1;
        #1;
        n_compared++; if (way_ren3 !== 4'b0000) begin n_mismatched++; $display("FAIL rst_mid_ren: got %b exp 0000", way_ren3); end
        n_compared++; if (rsp_valid3 !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_valid: got %b exp 0", rsp_valid3); end
        n_compared++; if (rsp_data3 !== 32'h0) begin n_mismatched++; $display("FAIL rst_mid_data: got %h exp 0", rsp_data3); end
        n_compared++; if (req_ready3 !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_ready: got %b exp 0", req_ready3); end
        tick();
        rst = 1'b0;
        #1;
        n_compared++; if (req_ready3 !== 1'b1) begin n_mismatched++; $display("FAIL rst_release_ready: got %b exp 1", req_ready3); end
        quiet_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid3 !== 1'b0 || way_ren3 !== 4'b0000) quiet_ok = 1'b0;
        end
        n_compared++; if (quiet_ok !== 1'b1) begin n_mismatched++; $display("FAIL rst_no_response: got valid=%b ren=%b exp 0 0000", rsp_valid3, way_ren3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_latency3();
        test_backpressure();
        test_multihot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
